// File: rtl/nms_line_sram_if.sv
// SRAM pin bundle between the NMS initiator (master) and the line-buffer SRAM (slave).
// Port A writes, port B reads; write enables are active low.
interface nms_line_sram_if #(
    parameter int DWIDTH = 20,
    parameter int AWIDTH = 10
) ();
    logic              sram_WENA;
    logic              sram_WENB;
    logic [DWIDTH-1:0] sram_DA;
    logic [DWIDTH-1:0] sram_DB;
    logic [AWIDTH-1:0] sram_AA;
    logic [AWIDTH-1:0] sram_AB;
    logic [DWIDTH-1:0] sram_QA;
    logic [DWIDTH-1:0] sram_QB;

    modport master (
        output sram_WENA, sram_WENB, sram_DA, sram_DB, sram_AA, sram_AB,
        input  sram_QA, sram_QB
    );

    modport slave (
        input  sram_WENA, sram_WENB, sram_DA, sram_DB, sram_AA, sram_AB,
        output sram_QA, sram_QB
    );
endinterface

// File: rtl/nms_line_sram.sv
// Dual-port read-first line-buffer SRAM for the NMS candidate delay, with a post-reset clear sweep.
// Optional SRAM_PARITY_EN adds an even-parity bit per word and a sticky o_parity_err output.
module nms_line_sram #(
    parameter int DEPTH  = 640,
    parameter int DWIDTH = 20,
    parameter int AWIDTH = 10
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clear,
    nms_line_sram_if.slave  sram,
    output logic            o_busy,
    output logic            o_addr_err
`ifdef SRAM_PARITY_EN
    ,
    output logic            o_parity_err
`endif
);

`ifdef SRAM_PARITY_EN
    localparam int MWIDTH = DWIDTH + 1;
`else
    localparam int MWIDTH = DWIDTH;
`endif

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t              state;
    logic [AWIDTH-1:0]   cnt;
    logic [MWIDTH-1:0]   mem [DEPTH];
    logic [MWIDTH-1:0]   word_a;
    logic [MWIDTH-1:0]   word_b;
    logic                in_a;
    logic                in_b;
    logic                wr_a;
    logic                wr_b;

    function automatic logic in_range(input logic [AWIDTH-1:0] addr);
        return 32'(addr) < 32'(DEPTH);
    endfunction

    function automatic logic [MWIDTH-1:0] pack_word(input logic [DWIDTH-1:0] d);
`ifdef SRAM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    // Out-of-range addresses never touch the array; their reads return zero.
    always_comb begin
        in_a   = in_range(sram.sram_AA);
        in_b   = in_range(sram.sram_AB);
        wr_a   = (state == ST_READY) && !sram.sram_WENA && in_a;
        wr_b   = (state == ST_READY) && !sram.sram_WENB && in_b;
        word_a = '0;
        word_b = '0;
        if (in_a) word_a = mem[sram.sram_AA];
        if (in_b) word_b = mem[sram.sram_AB];
    end

    // NOTE: the storage array has no reset term -- reset cannot clear a RAM macro, so the clear
    // sweep does that job; port B is written before port A so A wins a same-address collision.
    always_ff @(posedge i_clk) begin
        if (state == ST_CLEAR) begin
            mem[cnt] <= '0;
        end else begin
            if (wr_b) mem[sram.sram_AB] <= pack_word(sram.sram_DB);
            if (wr_a) mem[sram.sram_AA] <= pack_word(sram.sram_DA);
        end
    end

    // NOTE: all state uses non-blocking assignments, so Q loads the pre-write word (read-first).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_CLEAR;
            cnt          <= '0;
            o_busy       <= 1'b1;
            o_addr_err   <= 1'b0;
            sram.sram_QA <= '0;
            sram.sram_QB <= '0;
`ifdef SRAM_PARITY_EN
            o_parity_err <= 1'b0;
`endif
        end else begin
            case (state)
                ST_CLEAR: begin
                    sram.sram_QA <= '0;
                    sram.sram_QB <= '0;
                    if (i_clear) begin
                        cnt <= '0;
                    end else if (cnt == LAST_ADDR) begin
                        cnt    <= '0;
                        state  <= ST_READY;
                        o_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + AWIDTH'(1);
                    end
                end
                ST_READY: begin
                    sram.sram_QA <= word_a[DWIDTH-1:0];
                    sram.sram_QB <= word_b[DWIDTH-1:0];
                    if (!in_a || !in_b) o_addr_err <= 1'b1;
`ifdef SRAM_PARITY_EN
                    if ((in_a && ^word_a) || (in_b && ^word_b)) o_parity_err <= 1'b1;
`endif
                    if (i_clear) begin
                        state  <= ST_CLEAR;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_CLEAR;
                    cnt    <= '0;
                    o_busy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nms_line_sram.sv
// Scoreboard bench for nms_line_sram: a reference array predicts QA/QB/o_addr_err for every
// cycle, plus clear-sweep length checks after reset and after an i_clear pulse.
module tb_nms_line_sram;

    localparam int DEPTH  = 640;
    localparam int DWIDTH = 20;
    localparam int AWIDTH = 10;

    typedef struct {
        string             tag;
        logic [DWIDTH-1:0] qa;
        logic [DWIDTH-1:0] qb;
        logic              err;
    } exp_t;

    logic i_clk;
    logic i_rst_n;
    logic i_clear;
    logic o_busy;
    logic o_addr_err;
`ifdef SRAM_PARITY_EN
    logic o_parity_err;
`endif

    nms_line_sram_if #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) sram ();

    nms_line_sram #(.DEPTH(DEPTH), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (i_clear),
        .sram       (sram),
        .o_busy     (o_busy),
        .o_addr_err (o_addr_err)
`ifdef SRAM_PARITY_EN
        ,
        .o_parity_err (o_parity_err)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int                n_vec = 0;
    int                n_err = 0;
    logic [DWIDTH-1:0] model [DEPTH];
    logic              exp_err;
    exp_t              sb [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // One access cycle, entered and left at a negedge: predict, clock, compare.
    task automatic step(input string tag, input logic wena, input int aa, input logic [DWIDTH-1:0] da,
                        input logic wenb, input int ab, input logic [DWIDTH-1:0] db);
        exp_t e;
        sram.sram_WENA = wena;
        sram.sram_AA   = AWIDTH'(aa);
        sram.sram_DA   = da;
        sram.sram_WENB = wenb;
        sram.sram_AB   = AWIDTH'(ab);
        sram.sram_DB   = db;
        e.tag = tag;
        e.qa  = '0;
        e.qb  = '0;
        if (aa < DEPTH) e.qa = model[aa];
        if (ab < DEPTH) e.qb = model[ab];
        if (aa >= DEPTH || ab >= DEPTH) exp_err = 1'b1;
        e.err = exp_err;
        if (!wenb && ab < DEPTH) model[ab] = db;
        if (!wena && aa < DEPTH) model[aa] = da;
        sb.push_back(e);
        @(posedge i_clk);
        @(negedge i_clk);
        e = sb.pop_front();
        check({e.tag, "_qa"}, 32'(sram.sram_QA), 32'(e.qa));
        check({e.tag, "_qb"}, 32'(sram.sram_QB), 32'(e.qb));
        check({e.tag, "_addr_err"}, 32'(o_addr_err), 32'(e.err));
    endtask

    // Counts negedge samples with o_busy high, starting at the current negedge; bounded.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!o_busy) break;
            n++;
            @(negedge i_clk);
        end
    endtask

    initial begin
        int busy_len;
        i_rst_n        = 1'b0;
        i_clear        = 1'b0;
        exp_err        = 1'b0;
        sram.sram_WENA = 1'b1;
        sram.sram_WENB = 1'b1;
        sram.sram_AA   = '0;
        sram.sram_AB   = '0;
        sram.sram_DA   = '0;
        sram.sram_DB   = '0;
        repeat (3) @(negedge i_clk);
        check("rst_qa", 32'(sram.sram_QA), 32'h0);
        check("rst_qb", 32'(sram.sram_QB), 32'h0);
        check("rst_busy", 32'(o_busy), 32'h1);
        check("rst_addr_err", 32'(o_addr_err), 32'h0);

        i_rst_n = 1'b1;
        count_busy(busy_len);
        check("sweep_len", 32'(busy_len), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        step("rd0", 1'b1, 0, '0, 1'b1, 0, '0);
        step("rd1", 1'b1, 0, '0, 1'b1, 1, '0);
        step("rd639", 1'b1, 0, '0, 1'b1, 639, '0);

        step("wr5", 1'b0, 5, 20'hABCDE, 1'b1, 0, '0);
        step("rd5", 1'b1, 0, '0, 1'b1, 5, '0);

        step("wr7", 1'b0, 7, 20'h11111, 1'b1, 0, '0);
        step("col7", 1'b0, 7, 20'h22222, 1'b1, 7, '0);
        step("rd7", 1'b1, 7, '0, 1'b1, 7, '0);

        step("dw9", 1'b0, 9, 20'h0000A, 1'b0, 9, 20'h0000B);
        step("rd9", 1'b1, 9, '0, 1'b1, 9, '0);

        step("oor", 1'b0, DEPTH, 20'hFFFFF, 1'b1, 0, '0);
        for (int i = 0; i < DEPTH; i++) step("scan", 1'b1, DEPTH - 1 - i, '0, 1'b1, i, '0);

        // Streaming delay-line use, with i_clear landing 300 words into the third row.
        for (int t = 0; t < 2 * DEPTH + 300; t++) begin
            if (t == 2 * DEPTH + 299) i_clear = 1'b1;
            step("nms", 1'b0, (DEPTH - 16 + t) % DEPTH, DWIDTH'($urandom), 1'b1, t % DEPTH, '0);
            i_clear = 1'b0;
        end

        // Writes during the sweep must be ignored.
        sram.sram_WENA = 1'b0;
        sram.sram_AA   = AWIDTH'(3);
        sram.sram_DA   = 20'h12345;
        count_busy(busy_len);
        check("clear_len", 32'(busy_len), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int i = 0; i < DEPTH; i++) step("post_clr", 1'b1, DEPTH - 1 - i, '0, 1'b1, i, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
